// File: rtl/lcd_text_ctrl.sv
// rtl/lcd_text_ctrl.sv - HD44780 8-bit write-only text controller: power-up, init, multi-line refresh.
// Optional macro LCD_AUTO_REFRESH_EN: refresh whenever text differs from the last snapshot.
module lcd_text_ctrl #(
  parameter int NUM_LINES     = 2,
  parameter int LINE_LEN      = 16,
  parameter int PULSE_WIDTH   = 10,
  parameter int CMD_DELAY     = 20000,
  parameter int CLEAR_DELAY   = 100000,
  parameter int POWERUP_DELAY = 1000000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [8*NUM_LINES*LINE_LEN-1:0] text,
  input  logic                            update,
  output logic                            busy,
  output logic                            RS,
  output logic                            E,
  output logic [7:0]                      DB
);

  localparam int MAX_A = (POWERUP_DELAY > CLEAR_DELAY) ? POWERUP_DELAY : CLEAR_DELAY;
  localparam int MAX_B = (CMD_DELAY > PULSE_WIDTH) ? CMD_DELAY : PULSE_WIDTH;
  localparam int MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAX_D + 1);
  localparam int COL_W = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;

  localparam logic [CNT_W-1:0] PU_LAST  = CNT_W'(POWERUP_DELAY);
  localparam logic [CNT_W-1:0] PW_LAST  = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_DELAY - 1);
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLEAR_DELAY - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_LEN - 1);
  localparam logic             LINE_LAST = (NUM_LINES == 2);
  localparam logic [7:0]       FUNC_SET  = (NUM_LINES == 2) ? 8'h38 : 8'h30;

  typedef enum logic [2:0] {S_POWERUP, S_SETUP, S_PULSE, S_WAIT, S_IDLE} state_t;
  typedef enum logic [1:0] {K_INIT, K_ADDR, K_CHAR} kind_t;

  state_t                          state, state_n;
  kind_t                           kind, kind_n;
  logic [1:0]                      idx, idx_n;
  logic                            line, line_n;
  logic [COL_W-1:0]                col, col_n;
  logic [CNT_W-1:0]                cnt, cnt_n;
  logic                            pending, pending_n;
  logic                            take_snap;
  logic [8*NUM_LINES*LINE_LEN-1:0] snap;
  logic                            request;
  logic [CNT_W-1:0]                wait_last;
  logic [7:0]                      cur_byte;
  int                              char_idx;
  logic                            in_tx;

`ifdef LCD_AUTO_REFRESH_EN
  assign request = update | (text != snap);
`else
  assign request = update;
`endif

  assign busy      = (state != S_IDLE);
  assign in_tx     = (state == S_SETUP) || (state == S_PULSE) || (state == S_WAIT);
  assign wait_last = (kind == K_INIT && idx == 2'd2) ? CLR_LAST : CMD_LAST;
  assign E         = (state == S_PULSE);
  assign RS        = in_tx && (kind == K_CHAR);
  assign DB        = in_tx ? cur_byte : 8'h00;

  // Byte currently on the bus; the character is picked from the refresh snapshot.
  always_comb begin
    cur_byte = 8'h00;
    char_idx = (line ? LINE_LEN : 0) + int'(col);
    unique case (kind)
      K_INIT: begin
        unique case (idx)
          2'd0:    cur_byte = FUNC_SET;
          2'd1:    cur_byte = 8'h0C;
          2'd2:    cur_byte = 8'h01;
          default: cur_byte = 8'h06;
        endcase
      end
      K_ADDR: cur_byte = line ? 8'hC0 : 8'h80;
      K_CHAR: begin
        for (int k = 0; k < NUM_LINES*LINE_LEN; k++)
          if (k == char_idx) cur_byte = snap[8*k +: 8];
      end
      default: cur_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_n   = state;
    kind_n    = kind;
    idx_n     = idx;
    line_n    = line;
    col_n     = col;
    cnt_n     = cnt;
    pending_n = pending;
    take_snap = 1'b0;
    if (busy && request) pending_n = 1'b1;
    unique case (state)
      S_POWERUP: begin
        if (cnt == PU_LAST) begin
          state_n = S_SETUP;
          kind_n  = K_INIT;
          idx_n   = 2'd0;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_SETUP: begin
        state_n = S_PULSE;
        cnt_n   = '0;
      end
      S_PULSE: begin
        if (cnt == PW_LAST) begin
          state_n = S_WAIT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt == wait_last) begin
          cnt_n   = '0;
          state_n = S_SETUP;
          unique case (kind)
            K_INIT: begin
              if (idx == 2'd3) begin
                kind_n    = K_ADDR;
                line_n    = 1'b0;
                col_n     = '0;
                take_snap = 1'b1;
              end else begin
                idx_n = idx + 2'd1;
              end
            end
            K_ADDR: begin
              kind_n = K_CHAR;
              col_n  = '0;
            end
            K_CHAR: begin
              if (col != COL_LAST) begin
                col_n = col + 1'b1;
              end else if (line != LINE_LAST) begin
                kind_n = K_ADDR;
                line_n = 1'b1;
              end else if (pending || request) begin
                // Back-to-back refresh: busy never drops.
                kind_n    = K_ADDR;
                line_n    = 1'b0;
                col_n     = '0;
                take_snap = 1'b1;
                pending_n = 1'b0;
              end else begin
                state_n = S_IDLE;
              end
            end
            default: state_n = S_IDLE;
          endcase
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_IDLE: begin
        if (request) begin
          state_n   = S_SETUP;
          kind_n    = K_ADDR;
          line_n    = 1'b0;
          col_n     = '0;
          cnt_n     = '0;
          take_snap = 1'b1;
        end
      end
      default: state_n = S_POWERUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_POWERUP;
      kind    <= K_INIT;
      idx     <= 2'd0;
      line    <= 1'b0;
      col     <= '0;
      cnt     <= '0;
      pending <= 1'b0;
      snap    <= '0;
    end else begin
      state   <= state_n;
      kind    <= kind_n;
      idx     <= idx_n;
      line    <= line_n;
      col     <= col_n;
      cnt     <= cnt_n;
      pending <= pending_n;
      if (take_snap) snap <= text;
    end
  end

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// tb/tb_lcd_text_ctrl.sv - scoreboard bench for lcd_text_ctrl (E-strobe monitor vs. string-level model).
module tb_lcd_text_ctrl;
  localparam int NL = 2, LL = 4, PW = 2, CD = 4, CLD = 8, PUD = 10;

  logic clk = 1'b0, reset = 1'b1, update = 1'b0;
  logic [8*NL*LL-1:0] text = '0;
  logic busy, RS, E;
  logic [7:0] DB;

  lcd_text_ctrl #(.NUM_LINES(NL), .LINE_LEN(LL), .PULSE_WIDTH(PW), .CMD_DELAY(CD),
                  .CLEAR_DELAY(CLD), .POWERUP_DELAY(PUD)) dut (
    .clk(clk), .reset(reset), .text(text), .update(update),
    .busy(busy), .RS(RS), .E(E), .DB(DB));

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int cyc = -1, strobes = 0, falls = 0;
  logic [8:0] exp_q[$];
  string cur0 = "    ", cur1 = "    ";

  always @(posedge clk) cyc <= reset ? -1 : cyc + 1;

  task automatic check(input bit ok, input string name, input int act, input int want);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic logic [8*NL*LL-1:0] pack(input string l0, input string l1);
    logic [8*NL*LL-1:0] v = '0;
    for (int i = 0; i < LL; i++) begin
      v[8*i +: 8]      = l0[i];
      v[8*(LL+i) +: 8] = l1[i];
    end
    return v;
  endfunction

  function automatic string rand_line();
    string s = "    ";
    for (int i = 0; i < LL; i++) s.putc(i, byte'($urandom_range(32, 126)));
    return s;
  endfunction

  task automatic set_text(input string l0, input string l1);
    cur0 = l0;
    cur1 = l1;
    text = pack(l0, l1);
  endtask

  task automatic push_refresh(input string l0, input string l1);
    exp_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < LL; i++) exp_q.push_back({1'b1, l0[i]});
    exp_q.push_back({1'b0, 8'hC0});
    for (int i = 0; i < LL; i++) exp_q.push_back({1'b1, l1[i]});
  endtask

  task automatic expect_boot();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
    push_refresh(cur0, cur1);
`ifdef LCD_AUTO_REFRESH_EN
    // The cleared snapshot differs from nonzero text during power-up, so a second pass is queued.
    if (text != '0) push_refresh(cur0, cur1);
`endif
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(busy === 1'b0, "idle_timeout", busy, 0);
    check(exp_q.size() == 0, "sb_drained", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic start_refresh(input string l0, input string l1);
    @(negedge clk);
    set_text(l0, l1);
    update = 1'b1;
    push_refresh(l0, l1);
    @(negedge clk);
    update = 1'b0;
    check({busy, RS, E, DB} == {3'b100, 8'h80}, "idle_to_addr", {busy, RS, E, DB}, {3'b100, 8'h80});
  endtask

  // Monitor: every E rise is one byte delivered to the LCD.
  logic       prev_e = 1'b0, prev_rs = 1'b0, prev_busy = 1'b1;
  logic [7:0] prev_db = 8'h00;
  logic [8:0] last_byte = '0, want;
  logic       have_last = 1'b0, last_clear = 1'b0, busy_cont = 1'b0, boot = 1'b1;
  int         last_rise = 0, pulse_len = 0;

  always @(negedge clk) begin
    if (reset) begin
      prev_e = 1'b0; prev_busy = 1'b1; have_last = 1'b0; boot = 1'b1; pulse_len = 0;
    end else begin
      if (E && !prev_e) begin
        strobes++;
        if (boot) begin
          check(cyc == PUD + 1, "first_rise_cycle", cyc, PUD + 1);
          boot = 1'b0;
        end
        check({prev_rs, prev_db} == {RS, DB}, "setup_cycle", {prev_rs, prev_db}, {RS, DB});
        if (have_last && busy_cont)
          check(cyc - last_rise == 1 + PW + (last_clear ? CLD : CD), "tx_interval",
                cyc - last_rise, 1 + PW + (last_clear ? CLD : CD));
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_strobe", {RS, DB}, 0);
        end else begin
          want = exp_q.pop_front();
          check({RS, DB} == want, "strobe_byte", {RS, DB}, want);
        end
        last_rise  = cyc;
        last_byte  = {RS, DB};
        last_clear = ({RS, DB} == 9'h001);
        have_last  = 1'b1;
        busy_cont  = 1'b1;
        pulse_len  = 1;
      end else if (E) begin
        pulse_len++;
      end else if (prev_e) begin
        check(pulse_len == PW, "pulse_width", pulse_len, PW);
        check({RS, DB} == last_byte, "hold_after_fall", {RS, DB}, last_byte);
      end
      if (!busy) busy_cont = 1'b0;
      if (prev_busy && !busy) begin
        falls++;
        if (have_last) check(cyc == last_rise + PW + CD, "busy_fall_cycle", cyc, last_rise + PW + CD);
        check({E, RS, DB} == 10'd0, "idle_outputs", {E, RS, DB}, 0);
      end
      prev_e = E; prev_rs = RS; prev_db = DB; prev_busy = busy;
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s, f, k;
    string o0, o1;
    // Reset state and power-up/init sequence followed by the automatic first refresh.
    repeat (3) @(negedge clk);
    check({busy, RS, E, DB} == {3'b100, 8'h00}, "reset_state", {busy, RS, E, DB}, {3'b100, 8'h00});
    set_text("ABCD", "WXYZ");
    reset = 1'b0;
    expect_boot();
    wait_idle();

    // Randomised refreshes.
    for (int r = 0; r < 5; r++) begin
      start_refresh(rand_line(), rand_line());
      wait_idle();
    end

    // Text change mid-refresh: the running refresh keeps the old snapshot.
    start_refresh(rand_line(), rand_line());
    repeat ($urandom_range(5, 40)) @(negedge clk);
    set_text(rand_line(), rand_line());
`ifdef LCD_AUTO_REFRESH_EN
    push_refresh(cur0, cur1);
`endif
    wait_idle();
    s = strobes;
    repeat (100) @(negedge clk);
    check(strobes == s, "no_spurious_refresh", strobes - s, 0);

    // Several requests while busy collapse into exactly one extra refresh.
    start_refresh(rand_line(), rand_line());
    f = falls;
    repeat ($urandom_range(2, 30)) @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      update = 1'b1;
      @(negedge clk);
      update = 1'b0;
      repeat ($urandom_range(1, 5)) @(negedge clk);
    end
    push_refresh(cur0, cur1);
    wait_idle();
    check(falls == f + 1, "collapsed_busy_falls", falls - f, 1);

    // Update arriving on the very edge where the final WAIT expires.
    start_refresh(rand_line(), rand_line());
    f = falls;
    repeat (69) @(negedge clk);
    update = 1'b1;
    push_refresh(cur0, cur1);
    @(negedge clk);
    update = 1'b0;
    wait_idle();
    check(falls == f + 1, "edge_update_busy_falls", falls - f, 1);

    // Reset in the middle of the E pulse of character 'B'.
    start_refresh("ABCD", "WXYZ");
    k = 0;
    while (!(E && RS && DB == 8'h42) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check(E && RS && DB == 8'h42, "find_B_pulse", DB, 8'h42);
    reset = 1'b1;
    @(negedge clk);
    check({busy, E, DB} == {2'b10, 8'h00}, "reset_mid_pulse", {busy, E, DB}, {2'b10, 8'h00});
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    expect_boot();
    wait_idle();

`ifdef LCD_AUTO_REFRESH_EN
    // One changed byte while idle starts a refresh on the next edge.
    @(negedge clk);
    o0 = cur0;
    o1 = cur1;
    o1.putc(2, byte'(o1[2] ^ 8'h01));
    set_text(o0, o1);
    push_refresh(o0, o1);
    @(negedge clk);
    check({busy, DB} == {1'b1, 8'h80}, "auto_start", {busy, DB}, {1'b1, 8'h80});
    wait_idle();
    s = strobes;
    repeat (100) @(negedge clk);
    check(strobes == s, "auto_quiet", strobes - s, 0);
`endif

    check(exp_q.size() == 0, "sb_leftover", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
